demod_tti_timer_gen: RTL and testbench

- Parametrised multi-channel TTI timing generator for the demod subsystem.
- Generates the TTI tick and frame/subframe info (TtiInfo).
- Raises per-channel programmable demod timer interrupts, subframe-masked pseudo-DCI interrupts and a DSP sync interrupt.
- Generalises the fixed single TtiTick/DemodTimerInt scheme to NUM_CH channels with resync and overrun detection.
- Sits between the system timing registers and the demod/DSP interrupt aggregation.

---
 rtl/demod_timer_pkg.sv | 27 ++
 rtl/demod_ch_timer_int.sv | 37 +++
 rtl/demod_tti_timer_gen.sv | 91 +++++++++
 tb/tb_demod_tti_timer_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demod_timer_pkg.sv
// rtl/demod_timer_pkg.sv - shared TTI timing types, default sizes and frame/subframe wrap arithmetic
package demod_timer_pkg;

  localparam int DEF_NUM_SF = 10;
  localparam int DEF_SFN_W  = 10;
  localparam int DEF_SF_W   = 4;

  typedef struct packed {
    logic [DEF_SFN_W-1:0] sfn;
    logic [DEF_SF_W-1:0]  sf;
  } tti_info_t;

  // Subframe steps to the next one; after the last subframe the frame number
  // advances and wraps naturally at its width.
  function automatic tti_info_t next_tti_info(input tti_info_t cur);
    tti_info_t nxt;
    nxt = cur;
    if (cur.sf >= DEF_SF_W'(DEF_NUM_SF - 1)) begin
      nxt.sf  = '0;
      nxt.sfn = cur.sfn + DEF_SFN_W'(1);
    end else begin
      nxt.sf = cur.sf + DEF_SF_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/demod_ch_timer_int.sv
// rtl/demod_ch_timer_int.sv - one channel's offset compare with sticky interrupt and overrun flags
module demod_ch_timer_int
  import demod_timer_pkg::*;
#(
  parameter int TTI_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fireEn,
  input  logic [TTI_CNT_W-1:0] ttiCount,
  input  logic [TTI_CNT_W-1:0] chOffset,
  input  logic [TTI_CNT_W-1:0] period,
  input  logic                 intClr,
  output logic                 demodTimerInt,
  output logic                 intOverrun
);

  logic fire;

  // The count can sit past the period for one cycle after a period cut, so
  // offsets outside the current period are excluded explicitly.
  assign fire = fireEn && (ttiCount == chOffset) && (chOffset < period);

  always_ff @(posedge clk) begin
    if (reset) begin
      demodTimerInt <= 1'b0;
      intOverrun    <= 1'b0;
    end else if (fire) begin
      demodTimerInt <= 1'b1;
      intOverrun    <= !intClr && (intOverrun || demodTimerInt);
    end else if (intClr) begin
      demodTimerInt <= 1'b0;
      intOverrun    <= 1'b0;
    end
  end

endmodule

// File: rtl/demod_tti_timer_gen.sv
// rtl/demod_tti_timer_gen.sv - multi-channel TTI tick, frame/subframe and demod interrupt generator
module demod_tti_timer_gen #(
  parameter int NUM_CH    = 6,
  parameter int TTI_CNT_W = 16,
  parameter int SFN_W     = demod_timer_pkg::DEF_SFN_W,
  parameter int SF_W      = demod_timer_pkg::DEF_SF_W,
  parameter int NUM_SF    = demod_timer_pkg::DEF_NUM_SF
) (
  input  logic                        SystemClock,
  input  logic                        Reset,
  input  logic                        TimerEn,
  input  logic [TTI_CNT_W-1:0]        TtiPeriod,
  input  logic                        SyncReq,
  input  logic [SFN_W-1:0]            SyncSfn,
  input  logic [SF_W-1:0]             SyncSf,
  input  logic [NUM_CH-1:0]           ChEn,
  input  logic [NUM_CH*TTI_CNT_W-1:0] ChOffset,
  input  logic [NUM_CH-1:0]           IntClr,
  input  logic [NUM_SF-1:0]           PseudoDciSfMask,
  output logic                        TtiTick,
  output logic [SFN_W+SF_W-1:0]       TtiInfo,
  output logic [TTI_CNT_W-1:0]        TtiCount,
  output logic [NUM_CH-1:0]           DemodTimerInt,
  output logic [NUM_CH-1:0]           IntOverrun,
  output logic                        SpPseudoDciInt,
  output logic                        SyncIntDsp
);
  import demod_timer_pkg::*;

  logic [TTI_CNT_W-1:0] period;
  logic [TTI_CNT_W-1:0] ttiCountQ;
  logic [SF_W-1:0]      syncSfClip;
  tti_info_t            ttiInfoQ;
  tti_info_t            nextInfo;
  logic                 wrap;

  assign period     = (TtiPeriod < TTI_CNT_W'(2)) ? TTI_CNT_W'(2) : TtiPeriod;
  assign wrap       = TimerEn && (ttiCountQ >= period - TTI_CNT_W'(1));
  assign nextInfo   = next_tti_info(ttiInfoQ);
  assign syncSfClip = (SyncSf >= SF_W'(NUM_SF)) ? '0 : SyncSf;

  // Resync outranks a coincident wrap: it restarts the TTI without a tick.
  always_ff @(posedge SystemClock) begin
    if (Reset) begin
      ttiCountQ      <= '0;
      ttiInfoQ       <= '0;
      TtiTick        <= 1'b0;
      SpPseudoDciInt <= 1'b0;
      SyncIntDsp     <= 1'b0;
    end else if (SyncReq) begin
      ttiCountQ      <= '0;
      ttiInfoQ.sfn   <= SyncSfn;
      ttiInfoQ.sf    <= syncSfClip;
      TtiTick        <= 1'b0;
      SpPseudoDciInt <= 1'b0;
      SyncIntDsp     <= 1'b1;
    end else begin
      SyncIntDsp     <= 1'b0;
      TtiTick        <= wrap;
      SpPseudoDciInt <= wrap && PseudoDciSfMask[nextInfo.sf];
      if (wrap) begin
        ttiCountQ <= '0;
        ttiInfoQ  <= nextInfo;
      end else if (TimerEn) begin
        ttiCountQ <= ttiCountQ + TTI_CNT_W'(1);
      end
    end
  end

  assign TtiCount = ttiCountQ;
  assign TtiInfo  = ttiInfoQ;

  // Channels compare against the pre-update count, so a fire coincident with
  // a resync still uses the old position.
  for (genvar c = 0; c < NUM_CH; c++) begin : gChannel
    demod_ch_timer_int #(
      .TTI_CNT_W(TTI_CNT_W)
    ) uChTimerInt (
      .clk          (SystemClock),
      .reset        (Reset),
      .fireEn       (TimerEn & ChEn[c]),
      .ttiCount     (ttiCountQ),
      .chOffset     (ChOffset[c*TTI_CNT_W +: TTI_CNT_W]),
      .period       (period),
      .intClr       (IntClr[c]),
      .demodTimerInt(DemodTimerInt[c]),
      .intOverrun   (IntOverrun[c])
    );
  end

endmodule

// File: tb/tb_demod_tti_timer_gen.sv
// tb/tb_demod_tti_timer_gen.sv - scoreboard bench for demod_tti_timer_gen against a subframe-index reference model
module tb_demod_tti_timer_gen;

  localparam int NUM_CH = 6;
  localparam int CW     = 16;
  localparam int NUM_SF = 10;

  logic              SystemClock = 1'b0;
  logic              Reset = 1'b1;
  logic              TimerEn = 1'b0;
  logic [CW-1:0]     TtiPeriod = '0;
  logic              SyncReq = 1'b0;
  logic [9:0]        SyncSfn = '0;
  logic [3:0]        SyncSf = '0;
  logic [NUM_CH-1:0] ChEn = '0;
  logic [NUM_CH*CW-1:0] ChOffset = '0;
  logic [NUM_CH-1:0] IntClr = '0;
  logic [NUM_SF-1:0] PseudoDciSfMask = '0;
  logic              TtiTick;
  logic [13:0]       TtiInfo;
  logic [CW-1:0]     TtiCount;
  logic [NUM_CH-1:0] DemodTimerInt;
  logic [NUM_CH-1:0] IntOverrun;
  logic              SpPseudoDciInt;
  logic              SyncIntDsp;

  demod_tti_timer_gen dut (
    .SystemClock    (SystemClock),
    .Reset          (Reset),
    .TimerEn        (TimerEn),
    .TtiPeriod      (TtiPeriod),
    .SyncReq        (SyncReq),
    .SyncSfn        (SyncSfn),
    .SyncSf         (SyncSf),
    .ChEn           (ChEn),
    .ChOffset       (ChOffset),
    .IntClr         (IntClr),
    .PseudoDciSfMask(PseudoDciSfMask),
    .TtiTick        (TtiTick),
    .TtiInfo        (TtiInfo),
    .TtiCount       (TtiCount),
    .DemodTimerInt  (DemodTimerInt),
    .IntOverrun     (IntOverrun),
    .SpPseudoDciInt (SpPseudoDciInt),
    .SyncIntDsp     (SyncIntDsp)
  );

  always #5 SystemClock = ~SystemClock;

  // Reference state: the frame position is tracked as a linear subframe index.
  int          mCount = 0;
  int          mSubIdx = 0;
  logic [5:0]  mInt = '0;
  logic [5:0]  mOvr = '0;
  bit          mTick = 0, mPseudo = 0, mSync = 0;
  logic [44:0] expQ[$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic int offOf(int c);
    return int'(ChOffset[c*CW +: CW]);
  endfunction

  function automatic logic [44:0] packExp();
    logic [9:0] sfn;
    logic [3:0] sf;
    sfn = 10'(mSubIdx / NUM_SF);
    sf  = 4'(mSubIdx % NUM_SF);
    return {mTick, sfn, sf, CW'(mCount), mInt, mOvr, mPseudo, mSync};
  endfunction

  task automatic modelStep();
    int p;
    logic [5:0] fire;
    p = (TtiPeriod < 2) ? 2 : int'(TtiPeriod);
    for (int c = 0; c < NUM_CH; c++)
      fire[c] = TimerEn && ChEn[c] && (mCount == offOf(c)) && (offOf(c) < p);
    if (Reset) begin
      mCount = 0; mSubIdx = 0; mInt = '0; mOvr = '0;
      mTick = 0; mPseudo = 0; mSync = 0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (fire[c]) begin
          mOvr[c] = IntClr[c] ? 1'b0 : (mOvr[c] | mInt[c]);
          mInt[c] = 1'b1;
        end else if (IntClr[c]) begin
          mOvr[c] = 1'b0;
          mInt[c] = 1'b0;
        end
      end
      if (SyncReq) begin
        mCount = 0;
        mSubIdx = int'(SyncSfn) * NUM_SF + ((SyncSf >= NUM_SF) ? 0 : int'(SyncSf));
        mTick = 0; mPseudo = 0; mSync = 1;
      end else begin
        mSync = 0;
        if (TimerEn && mCount >= p - 1) begin
          mCount = 0;
          mSubIdx = (mSubIdx + 1) % (1024 * NUM_SF);
          mTick = 1;
          mPseudo = PseudoDciSfMask[mSubIdx % NUM_SF];
        end else begin
          mTick = 0; mPseudo = 0;
          if (TimerEn) mCount++;
        end
      end
    end
    expQ.push_back(packExp());
  endtask

  // One clock: the expectation is queued before the edge that produces it.
  task automatic cyc();
    modelStep();
    @(negedge SystemClock);
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic runUntilCount(int target);
    for (int i = 0; i < 200; i++) begin
      if (mCount == target) return;
      cyc();
    end
    miscompares++;
    $display("FAIL wait_count: count %0d never reached, model count %0d", target, mCount);
  endtask

  initial begin : monitor
    logic [44:0] exp, act;
    forever begin
      @(posedge SystemClock);
      #1;
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        act = {TtiTick, TtiInfo, TtiCount, DemodTimerInt, IntOverrun, SpPseudoDciInt, SyncIntDsp};
        vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("FAIL outputs @%0t: actual tick=%0b info=%0d/%0d cnt=%0d int=%h ovr=%h pdci=%0b sync=%0b, required tick=%0b info=%0d/%0d cnt=%0d int=%h ovr=%h pdci=%0b sync=%0b",
                   $time, act[44], act[43:34], act[33:30], act[29:14], act[13:8], act[7:2], act[1], act[0],
                   exp[44], exp[43:34], exp[33:30], exp[29:14], exp[13:8], exp[7:2], exp[1], exp[0]);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    @(negedge SystemClock);
    Reset = 1'b1;
    run(2);
    Reset = 1'b0;
    TtiPeriod = 16'd10;
    TimerEn = 1'b1;
    run(25);

    TtiPeriod = 16'd4;
    SyncReq = 1'b1; SyncSfn = 10'd1023; SyncSf = 4'd9;
    cyc();
    SyncReq = 1'b0;
    run(8);

    TtiPeriod = 16'd10;
    SyncReq = 1'b1; SyncSfn = 10'd0; SyncSf = 4'd0;
    cyc();
    SyncReq = 1'b0;
    run(7);
    SyncReq = 1'b1; SyncSfn = 10'd5; SyncSf = 4'd3;
    cyc();
    SyncReq = 1'b0;
    run(12);

    ChEn = 6'b000011;
    ChOffset[0 +: CW] = 16'd3;
    ChOffset[CW +: CW] = 16'd12;
    run(25);
    runUntilCount(3);
    IntClr = 6'b000001;
    cyc();
    IntClr = '0;
    run(5);

    PseudoDciSfMask = 10'b0000100100;
    run(70);
    TtiPeriod = 16'd1;
    run(10);
    TtiPeriod = 16'd0;
    run(6);
    TtiPeriod = 16'd10;
    run(3);
    runUntilCount(7);
    TtiPeriod = 16'd5;
    run(8);

    TtiPeriod = 16'd10;
    ChEn = 6'h3F;
    for (int c = 0; c < NUM_CH; c++) ChOffset[c*CW +: CW] = CW'(c);
    run(12);
    runUntilCount(6);
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    run(15);

    TimerEn = 1'b0;
    run(6);
    TimerEn = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) TtiPeriod = CW'($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0) ChEn = 6'($urandom);
      if ($urandom_range(0, 29) == 0)
        for (int c = 0; c < NUM_CH; c++) ChOffset[c*CW +: CW] = CW'($urandom_range(0, 13));
      if ($urandom_range(0, 49) == 0) PseudoDciSfMask = 10'($urandom);
      TimerEn = ($urandom_range(0, 9) != 0);
      SyncReq = ($urandom_range(0, 39) == 0);
      SyncSfn = 10'($urandom_range(0, 1023));
      SyncSf  = 4'($urandom_range(0, 15));
      IntClr  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : '0;
      Reset   = ($urandom_range(0, 299) == 0);
      cyc();
    end
    Reset = 1'b0; SyncReq = 1'b0; IntClr = '0;

    repeat (3) @(posedge SystemClock);
    #2;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
